// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with fetch queue and optional JAL prediction (FETCH_JAL_PRED_EN)
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FQ_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    output logic                  req_mc_out,
    output logic [ADDR_WIDTH-1:0] addr_mc_out,
    input  logic                  rdy_inst_mc_in,
    input  logic [31:0]           inst_mc_in,
    output logic                  inst_valid_out,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pred_taken_out,
    input  logic                  iq_ready_in,
    input  logic                  refresh_rob_in,
    input  logic [ADDR_WIDTH-1:0] new_pc_rob_in
);

    localparam int             PTR_W   = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STALE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic [ADDR_WIDTH-1:0]   pc_step;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    push_pred;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;
    logic [31:0]             inst_mem [FQ_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem   [FQ_DEPTH];

`ifdef FETCH_JAL_PRED_EN
    logic                    is_jal;
    logic [ADDR_WIDTH-1:0]   jal_imm;
    logic                    pred_mem [FQ_DEPTH];

    assign is_jal    = (inst_mc_in[6:0] == 7'b1101111);
    assign jal_imm   = {{(ADDR_WIDTH-20){inst_mc_in[31]}}, inst_mc_in[19:12],
                        inst_mc_in[20], inst_mc_in[30:21], 1'b0};
    assign pc_step   = is_jal ? jal_imm : ADDR_WIDTH'(4);
    assign push_pred = is_jal;

    // Prediction flag storage alongside each queued word
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            pred_mem[wr_ptr] <= push_pred;
        end
    end

    assign pred_taken_out = inst_valid_out ? pred_mem[rd_ptr] : 1'b0;
`else
    assign pc_step        = ADDR_WIDTH'(4);
    assign push_pred      = 1'b0;
    assign pred_taken_out = push_pred;
`endif

    // Next state: one outstanding request; a flushed request must still drain via STALE
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!refresh_rob_in && (count < DEPTH_C)) begin
                    state_next = S_WAIT;
                    issue      = 1'b1;
                end
            end
            S_WAIT: begin
                if (rdy_inst_mc_in) begin
                    state_next = S_IDLE;
                    push       = !refresh_rob_in;
                end else if (refresh_rob_in) begin
                    state_next = S_STALE;
                end
            end
            S_STALE: begin
                if (rdy_inst_mc_in) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Next PC: redirect wins, otherwise advance past an accepted word
    always_comb begin
        pc_next = pc;
        if (refresh_rob_in) begin
            pc_next = new_pc_rob_in;
        end else if (push) begin
            pc_next = pc + pc_step;
        end
    end

    assign pop = inst_valid_out && iq_ready_in && !refresh_rob_in;

    // State register, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // PC and request address; the address is latched at issue so it stays stable while outstanding
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc          <= RESET_PC;
            addr_mc_out <= RESET_PC;
        end else if (rdy_in) begin
            pc <= pc_next;
            if (issue) begin
                addr_mc_out <= pc;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (refresh_rob_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue payload storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            inst_mem[wr_ptr] <= inst_mc_in;
            pc_mem[wr_ptr]   <= pc;
        end
    end

    assign req_mc_out     = (state != S_IDLE);
    assign inst_valid_out = (count != '0);
    assign inst_out       = inst_valid_out ? inst_mem[rd_ptr] : 32'h0;
    assign pc_out         = inst_valid_out ? pc_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        rdy_inst;
    logic [31:0] inst_mc;
    logic        valid;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        pred;
    logic        iq_ready;
    logic        refresh;
    logic [31:0] new_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int r;
    int last_r;

`ifdef FETCH_JAL_PRED_EN
    localparam logic        JAL_PRED = 1'b1;
    localparam logic [31:0] JAL_NEXT = 32'h30;
`else
    localparam logic        JAL_PRED = 1'b0;
    localparam logic [31:0] JAL_NEXT = 32'h24;
`endif

    fetch_unit #(.ADDR_WIDTH(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy),
        .req_mc_out     (req),
        .addr_mc_out    (addr),
        .rdy_inst_mc_in (rdy_inst),
        .inst_mc_in     (inst_mc),
        .inst_valid_out (valid),
        .inst_out       (inst_o),
        .pc_out         (pc_o),
        .pred_taken_out (pred),
        .iq_ready_in    (iq_ready),
        .refresh_rob_in (refresh),
        .new_pc_rob_in  (new_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] wd(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rdy      = 1'b1;
        rdy_inst = 1'b0;
        inst_mc  = 32'h0;
        iq_ready = 1'b0;
        refresh  = 1'b0;
        new_pc   = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'b0, req}, 32'h1);
        chk({tag, "_addr"}, addr, exp_addr);
    endtask

    task automatic do_req(input string tag, input logic [31:0] exp_addr, input logic [31:0] word,
                          input logic exp_pred, input logic [31:0] head_pc,
                          input logic [31:0] head_inst, output int rcyc);
        wait_req(tag, exp_addr);
        rcyc = cyc;
        tick();
        rdy_inst = 1'b1;
        inst_mc  = word;
        tick();
        rdy_inst = 1'b0;
        inst_mc  = 32'h0;
        chk({tag, "_valid"}, {31'b0, valid}, 32'h1);
        chk({tag, "_pc"}, pc_o, head_pc);
        chk({tag, "_inst"}, inst_o, head_inst);
        chk({tag, "_pred"}, {31'b0, pred}, {31'b0, exp_pred});
        chk({tag, "_reqlow"}, {31'b0, req}, 32'h0);
    endtask

    initial begin
        // Reset values
        do_reset();
        rst_n = 1'b0;
        tick();
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pred", {31'b0, pred}, 32'h0);
        rst_n = 1'b1;

        // Streaming fetch, latency 1, consumer always ready
        iq_ready = 1'b1;
        last_r   = 0;
        for (int k = 0; k < 4; k++) begin
            do_req("t1", 32'(4 * k), wd(32'(4 * k)), 1'b0, 32'(4 * k), wd(32'(4 * k)), r);
            if (k > 0) chk("t1_spacing", 32'(r - last_r), 32'd3);
            last_r = r;
        end

        // Back-pressure: queue fills at four entries
        tick();
        iq_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_req("t2", 32'(16 + 4 * k), wd(32'(16 + 4 * k)), 1'b0, 32'h10, wd(32'h10), r);
        end
        repeat (6) tick();
        chk("t2_full_noreq", {31'b0, req}, 32'h0);
        chk("t2_full_valid", {31'b0, valid}, 32'h1);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        chk("t2_head_after_pop", pc_o, 32'h14);
        do_req("t2b", 32'h20, wd(32'h20), 1'b0, 32'h14, wd(32'h14), r);
        repeat (4) tick();
        chk("t2_single_req", {31'b0, req}, 32'h0);

        // Redirect while waiting: stale word discarded
        do_reset();
        do_req("t3a", 32'h0, wd(32'h0), 1'b0, 32'h0, wd(32'h0), r);
        do_req("t3b", 32'h4, wd(32'h4), 1'b0, 32'h0, wd(32'h0), r);
        wait_req("t3w", 32'h8);
        refresh = 1'b1;
        new_pc  = 32'h100;
        tick();
        refresh = 1'b0;
        chk("t3_flush_valid", {31'b0, valid}, 32'h0);
        chk("t3_stale_req", {31'b0, req}, 32'h1);
        chk("t3_stale_addr", addr, 32'h8);
        repeat (2) tick();
        chk("t3_stale_hold", addr, 32'h8);
        rdy_inst = 1'b1;
        inst_mc  = wd(32'h8);
        tick();
        rdy_inst = 1'b0;
        inst_mc  = 32'h0;
        chk("t3_drain_req", {31'b0, req}, 32'h0);
        chk("t3_drain_valid", {31'b0, valid}, 32'h0);
        tick();
        iq_ready = 1'b1;
        do_req("t3c", 32'h100, wd(32'h100), 1'b0, 32'h100, wd(32'h100), r);

        // Redirect coinciding with a response, two entries queued
        do_reset();
        do_req("t4a", 32'h0, wd(32'h0), 1'b0, 32'h0, wd(32'h0), r);
        do_req("t4b", 32'h4, wd(32'h4), 1'b0, 32'h0, wd(32'h0), r);
        wait_req("t4w", 32'h8);
        tick();
        rdy_inst = 1'b1;
        inst_mc  = wd(32'h8);
        refresh  = 1'b1;
        new_pc   = 32'h200;
        iq_ready = 1'b1;
        tick();
        rdy_inst = 1'b0;
        inst_mc  = 32'h0;
        refresh  = 1'b0;
        chk("t4_empty", {31'b0, valid}, 32'h0);
        chk("t4_idle", {31'b0, req}, 32'h0);
        do_req("t4c", 32'h200, wd(32'h200), 1'b0, 32'h200, wd(32'h200), r);

        // Freeze mid-wait with the response held
        do_reset();
        iq_ready = 1'b1;
        wait_req("t5w", 32'h0);
        tick();
        rdy_inst = 1'b1;
        inst_mc  = wd(32'h0);
        rdy      = 1'b0;
        repeat (5) tick();
        chk("t5_frz_req", {31'b0, req}, 32'h1);
        chk("t5_frz_valid", {31'b0, valid}, 32'h0);
        rdy = 1'b1;
        tick();
        rdy_inst = 1'b0;
        inst_mc  = 32'h0;
        chk("t5_push_valid", {31'b0, valid}, 32'h1);
        chk("t5_push_pc", pc_o, 32'h0);
        chk("t5_push_inst", inst_o, wd(32'h0));
        chk("t5_push_reqlow", {31'b0, req}, 32'h0);

        // JAL at 0x20, reached via a redirect taken in IDLE
        do_reset();
        refresh = 1'b1;
        new_pc  = 32'h20;
        tick();
        refresh = 1'b0;
        chk("t6_idle_redirect", {31'b0, req}, 32'h0);
        iq_ready = 1'b1;
        do_req("t6", 32'h20, 32'h0100006F, JAL_PRED, 32'h20, 32'h0100006F, r);
        wait_req("t6n", JAL_NEXT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage sitting between the memory controller and the instruction queue / decoder. It keeps a PC and issues one instruction-word request at a time to the memory controller. Returned words are buffered in an internal FIFO of `FQ_DEPTH` entries with a valid/ready output. On a ROB redirect it flushes all in-flight state, and it can optionally predict JAL targets so fetch follows unconditional jumps without waiting for the ROB.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC / address width.
- `FQ_DEPTH`, 4: fetch queue entries; power of two, ≥ 2.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk_in`  in  1  clock; all state on rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; when 0 all state holds.
- `req_mc_out`  out  1  instruction fetch request to memory controller.
- `addr_mc_out`  out  ADDR_WIDTH  request address; stable while `req_mc_out`=1.
- `rdy_inst_mc_in`  in  1  one-cycle pulse: `inst_mc_in` holds the word for the outstanding request.
- `inst_mc_in`  in  32  returned instruction word.
- `inst_valid_out`  out  1  queue head valid.
- `inst_out`  out  32  queue head instruction.
- `pc_out`  out  ADDR_WIDTH  queue head PC.
- `pred_taken_out`  out  1  head entry was fetch-redirected as a predicted JAL.
- `iq_ready_in`  in  1  consumer accepts head when `inst_valid_out`=1.
- `refresh_rob_in`  in  1  misprediction / flush.
- `new_pc_rob_in`  in  ADDR_WIDTH  redirect target.

## Operation
- FSM states: IDLE, WAIT, STALE.
  - IDLE → WAIT when `count < FQ_DEPTH` and no refresh. `req_mc_out` is driven to 1 and `addr_mc_out` to pc.
  - WAIT, response: push {inst, pc, pred}. The PC advances to pc+4, or to the JAL target when predicted. `req_mc_out` is driven to 0 and the FSM returns to IDLE.
  - WAIT, refresh: go to STALE. `req_mc_out` stays 1 with an unchanged address until the response arrives.
  - STALE, response: discard the word, drop `req_mc_out`, go to IDLE.
- At most one outstanding request.
- Room check counts the outstanding slot: a request is issued only if `count + (state==WAIT) < FQ_DEPTH`. A push therefore never overflows.
- Pop: `inst_valid_out && iq_ready_in` removes the head. Push and pop in the same cycle are allowed, and count is unchanged.
- Refresh, sampled only when `rdy_in`=1:
  - queue emptied (count=0);
  - pc <= `new_pc_rob_in`;
  - a response arriving in the same cycle is dropped;
  - a pop in the same cycle is ignored.
  - From IDLE the FSM stays in IDLE; from STALE it stays in STALE.
- Pointers wrap modulo `FQ_DEPTH`. Count ranges 0..`FQ_DEPTH`.
- PC arithmetic is modulo 2^ADDR_WIDTH.
- `rdy_in`=0 freezes FSM, pc, queue and outputs. Responses are not accepted while frozen; the memory controller is required to hold `rdy_inst_mc_in` until `rdy_in`=1.

## Timing
- Reset values (async):
  - `req_mc_out`=0, `addr_mc_out`=`RESET_PC`, pc=`RESET_PC`;
  - queue empty, `inst_valid_out`=0, `inst_out`=0, `pc_out`=0, `pred_taken_out`=0;
  - state IDLE.
- Reset asserted mid-request abandons the request; the memory controller is reset by the same signal.
- Request: issued 1 cycle after IDLE with room.
- Response: a pulse in cycle N makes the entry visible on `inst_valid_out` in N+1. The next request is at N+2.
- Outputs `inst_*`, `pc_out`, `pred_taken_out` come combinationally from the registered queue head.
- Refresh at edge E: `inst_valid_out`=0 from E. The first request to the new PC is at E+1 from IDLE, or one cycle after the stale response drains.

## Configuration
- `FETCH_JAL_PRED_EN` defined:
  - A returned word with opcode 7'b1101111 sets the next pc to pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - The entry is pushed with pred=1.
- `FETCH_JAL_PRED_EN` undefined: next pc is always pc+4, and `pred_taken_out` is tied 0. The port is still present.

## Test plan
- Reset release, memory latency 1, `iq_ready_in`=1: addresses 0,4,8,12 are requested. `pc_out` sequence is 0,4,8,12 with `inst_out` matching. Each request is spaced 3 cycles.
- `iq_ready_in`=0, FQ_DEPTH=4: exactly 4 requests are issued, then `req_mc_out` stays 0. Raising ready for one cycle produces one new request.
- Redirect to 0x100 while WAIT for 0x8: the 0x8 word is discarded. The next request is 0x100, and `pc_out` shows 0x100 first.
- Redirect in the same cycle as a response, with 2 entries queued: queue empty next cycle, and the response is not pushed.
- `rdy_in`=0 for 5 cycles mid-WAIT, with the response held: no state change. Pushed one cycle after `rdy_in`=1.
- `FETCH_JAL_PRED_EN`, word 0x0100006F at 0x20: entry has pred=1, and the next request is 0x30. With the macro off, the next request is 0x24 and pred=0.
